full_adder_reg: RTL and testbench

- Full adder: sum = a + b + cin, with carry-out.
- Default WIDTH=1 gives the classic 1-bit full adder (a, b, cin -> sum, carry).
- Wider operands use a ripple chain of 1-bit cells.
- Optional output register (default on) aligns the result to the system clock; used as a leaf arithmetic primitive in datapaths.

---
 rtl/full_adder_reg_pkg.sv | 14 +
 rtl/fa_cell.sv | 16 +
 rtl/full_adder_reg.sv | 67 ++++++
 tb/tb_full_adder_reg.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/full_adder_reg_pkg.sv
// Shared bit-level arithmetic for the full_adder_reg slice.
// The fa_cell uses these so the sum and majority equations live in one place.
package full_adder_reg_pkg;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Carry-out is the majority of the three inputs.
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// 1-bit combinational full adder: a + b + cin -> {cout, s}.
// Zero latency, no flow control; chained by full_adder_reg into a ripple adder.
module fa_cell
  import full_adder_reg_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = fa_sum(a, b, cin);
  assign cout = fa_carry(a, b, cin);

endmodule

// File: rtl/full_adder_reg.sv
// WIDTH-bit ripple-carry adder {carry, sum} = a + b + cin with optional output register.
// Latency 1 cycle when REG_OUT=1, 0 when REG_OUT=0; never stalls, accepts one operand set per cycle.
module full_adder_reg
  import full_adder_reg_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (sum_d[i]),
      .cout(c[i+1])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             vld_q;

    // Data only loads on in_valid so X on idle inputs never reaches the held result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
        vld_q   <= 1'b0;
      end else begin
        vld_q <= in_valid;
        if (in_valid) begin
          sum_q   <= sum_d;
          carry_q <= c[WIDTH];
        end
      end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = vld_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign sum       = sum_d;
    assign carry     = c[WIDTH];
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_full_adder_reg.sv
// Scoreboard bench for full_adder_reg at WIDTH 1/4/16 registered and WIDTH 8 combinational.
module tb_full_adder_reg;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        v1, ci1, co1, ov1;
  logic [0:0]  a1, b1, s1;
  logic        v4, ci4, co4, ov4;
  logic [3:0]  a4, b4, s4;
  logic        v8, ci8, co8, ov8;
  logic [7:0]  a8, b8, s8;
  logic        v16, ci16, co16, ov16;
  logic [15:0] a16, b16, s16;

  full_adder_reg #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(ci1),
    .sum(s1), .carry(co1), .out_valid(ov1));

  full_adder_reg #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cin(ci4),
    .sum(s4), .carry(co4), .out_valid(ov4));

  full_adder_reg #(.WIDTH(8), .REG_OUT(1'b0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(ci8),
    .sum(s8), .carry(co8), .out_valid(ov8));

  full_adder_reg #(.WIDTH(16), .REG_OUT(1'b1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .cin(ci16),
    .sum(s16), .carry(co16), .out_valid(ov16));

  typedef struct {
    logic        vld;
    logic [16:0] res;
  } exp_t;

  exp_t        q1[$], q4[$], q16[$];
  logic [16:0] hold1, hold4, hold16;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Compare one popped scoreboard entry; idle cycles expect the previous result held.
  task automatic check_reg(input string tag, input exp_t e, inout logic [16:0] hold,
                           input logic [16:0] obs, input logic ov);
    logic [16:0] want;
    chk({tag, ".out_valid"}, 17'(ov), 17'(e.vld));
    want = e.vld ? e.res : hold;
    chk({tag, ".result"}, obs, want);
    hold = want;
  endtask

  task automatic tick();
    exp_t e;
    e.vld = v1;  e.res = 17'(a1)  + 17'(b1)  + 17'(ci1);  q1.push_back(e);
    e.vld = v4;  e.res = 17'(a4)  + 17'(b4)  + 17'(ci4);  q4.push_back(e);
    e.vld = v16; e.res = 17'(a16) + 17'(b16) + 17'(ci16); q16.push_back(e);
    @(posedge clk);
    #1;
    e = q1.pop_front();
    check_reg("w1", e, hold1, 17'({co1, s1}), ov1);
    e = q4.pop_front();
    check_reg("w4", e, hold4, 17'({co4, s4}), ov4);
    e = q16.pop_front();
    check_reg("w16", e, hold16, 17'({co16, s16}), ov16);
  endtask

  task automatic check_comb(input string tag);
    logic [16:0] want;
    want = 17'(a8) + 17'(b8) + 17'(ci8);
    chk({tag, ".result"}, 17'({co8, s8}), want);
    chk({tag, ".out_valid"}, 17'(ov8), 17'(v8));
  endtask

  initial begin
    rst_n = 1'b0;
    v1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
    v4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;
    v8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A; ci8 = 1'b1;
    hold1 = '0; hold4 = '0; hold16 = '0;

    #3;
    chk("reset.w1", 17'({ov1, co1, s1}), 17'd0);
    chk("reset.w4", 17'({ov4, co4, s4}), 17'd0);
    chk("reset.w16", 17'({ov16, co16, s16}), 17'd0);
    // Combinational instance ignores reset and clock entirely.
    chk("comb.a5_5a", 17'({co8, s8}), 17'h100);
    chk("comb.valid_hi", 17'(ov8), 17'd1);
    v8 = 1'b0;
    #1;
    chk("comb.valid_lo", 17'(ov8), 17'd0);
    chk("comb.a5_5a_hold", 17'({co8, s8}), 17'h100);

    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive 1-bit table alongside the 4-bit boundary vectors.
    for (int i = 0; i < 8; i++) begin
      {a1, b1, ci1} = 3'(i);
      v1 = 1'b1;
      case (i)
        0:       begin a4 = 4'hF; b4 = 4'h1; ci4 = 1'b0; v4 = 1'b1; end
        1:       begin a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1; v4 = 1'b1; end
        2:       begin a4 = 4'h0; b4 = 4'h0; ci4 = 1'b0; v4 = 1'b1; end
        default: v4 = 1'b0;
      endcase
      tick();
      if (i == 0) chk("w4.F_plus_1", 17'({co4, s4}), 17'h10);
      if (i == 1) chk("w4.F_plus_F_c1", 17'({co4, s4}), 17'h1F);
      if (i == 2) chk("w4.zero", 17'({co4, s4}), 17'h00);
    end

    // Single valid then idle with unknown operands: result must be held.
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b0; v1 = 1'b1;
    tick();
    chk("latency.w1", 17'({ov1, co1, s1}), 17'b110);
    v1 = 1'b0; a1 = 'x; b1 = 'x; ci1 = 1'bx;
    tick();
    chk("hold.w1", 17'({ov1, co1, s1}), 17'b010);
    tick();

    // Async reset between edges while a 16-bit operand set is in flight.
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b0; v1 = 1'b1;
    a4 = 4'h9; b4 = 4'h9; ci4 = 1'b0; v4 = 1'b1;
    tick();
    v1 = 1'b0; v4 = 1'b0;
    a16 = 16'hFFFF; b16 = 16'h0001; ci16 = 1'b0; v16 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.w1", 17'({ov1, co1, s1}), 17'd0);
    chk("async_rst.w4", 17'({ov4, co4, s4}), 17'd0);
    chk("async_rst.w16", 17'({ov16, co16, s16}), 17'd0);
    @(posedge clk);
    #1;
    chk("rst_discard.w16", 17'({ov16, co16, s16}), 17'd0);
    v16 = 1'b0;
    #2;
    rst_n = 1'b1;
    hold1 = '0; hold4 = '0; hold16 = '0;
    tick();

    // Random traffic: 16-bit valid every cycle, narrower widths with random valid.
    for (int n = 0; n < 1000; n++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom); v16 = 1'b1;
      v4 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
      v1 = 1'($urandom);
      if (v1) begin
        a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
      end else begin
        a1 = 'x; b1 = 'x; ci1 = 1'bx;
      end
      tick();
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); v8 = 1'($urandom);
      #1;
      if (n % 50 == 0) check_comb("comb.rand_hi");
      #4;
      if (n % 50 == 0) check_comb("comb.rand_lo");
    end

    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
